sram_port_responder: RTL and testbench
======================================

SRAM_PORT_RESPONDER -- requirements
Module: sram_port_responder

Interface
REQ-001 SHALL have parameter DEPTH, default 512, meaning byte locations in the internal array.
REQ-002 SHALL have parameter PROT_BASE, default 32, meaning the lowest byte address of the write-protected program region.
REQ-003 SHALL have port clk, input, 1 bit, meaning the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit, meaning synchronous active-low reset sampled on the clk rising edge.
REQ-005 SHALL have port i_req, input, 1 bit, meaning the instruction-fetch request; held by the requester until i_ack.
REQ-006 SHALL have port i_addr, input, 8 bits, meaning the word address; byte address = {i_addr,1'b0}.
REQ-007 SHALL have port i_data, output, 16 bits, meaning the fetched word = {byte[2a+1], byte[2a]}.
REQ-008 SHALL have port i_ack, output, 1 bit, meaning a one-cycle pulse; i_data is valid in the same cycle.
REQ-009 SHALL have port d_req, input, 1 bit, meaning the data-access request; held until d_ack.
REQ-010 SHALL have port d_we, input, 1 bit, meaning 1 = write and 0 = read; sampled with d_req.
REQ-011 SHALL have port d_addr, input, 9 bits, meaning the byte address.
REQ-012 SHALL have port d_wdata, input, 8 bits, meaning the write byte.
REQ-013 SHALL have port d_rdata, output, 8 bits, meaning the read byte; valid while d_ack is high.
REQ-014 SHALL have port d_ack, output, 1 bit, meaning a one-cycle completion pulse.
REQ-015 SHALL have port d_err, output, 1 bit, meaning a one-cycle pulse, concurrent with d_ack, that flags a rejected write.

Function
REQ-016 SHALL implement FSM states IDLE, IF_LO, IF_HI, D_RD, D_WR and ACK.
REQ-017 SHALL evaluate requests in IDLE only, with d_req taking priority over i_req when both are high on the same edge.
REQ-018 SHALL go IDLE to IF_LO on i_req, IF_LO to IF_HI, then IF_HI to ACK, capturing the low byte and then the high byte; i_ack is high in the ACK cycle, 3 edges after acceptance.
REQ-019 SHALL go IDLE to D_RD to ACK for a data read, with d_ack high in the ACK cycle, 2 edges after acceptance.
REQ-020 SHALL go IDLE to D_WR to ACK for a data write, with the array updated on the D_WR edge and d_ack high in the ACK cycle.
REQ-021 SHALL always return from ACK to IDLE; a request still high in IDLE is treated as a new request.
REQ-022 SHALL NOT preempt an accepted transaction; requests arriving mid-transaction wait in IDLE.
REQ-023 SHALL, for addresses at or above DEPTH, return 0x00 on reads and drop writes; d_ack is still issued.
REQ-024 SHALL compute the fetch high-byte address as 2a+1 without wrap, so i_addr=255 reads bytes 510 and 511.
REQ-025 SHALL hold i_data and d_rdata at their last values outside the ack cycles.

Reset
REQ-026 SHALL, on rst_n=0 at a clk edge, set state to IDLE, i_ack, d_ack and d_err to 0, and i_data and d_rdata to 0.
REQ-027 SHALL, when reset occurs mid-transaction, abort the transaction with no ack pulse; a write is suppressed if reset and D_WR coincide.
REQ-028 SHALL leave array contents unchanged by reset.

Configuration
REQ-029 SHALL, with SRAM_WPROT_EN defined, reject data writes with d_addr >= PROT_BASE: the array is unchanged and d_err=1 with d_ack.
REQ-030 SHALL, without SRAM_WPROT_EN, accept all in-range writes, keep d_err tied to 0, and ignore PROT_BASE.

Structure
REQ-031 SHALL place the state encoding, address widths and the default PROT_BASE in a shared package used by the CPU-side and memory-side blocks.
REQ-032 SHALL instantiate one sub-module, sram_8bit_core: a DEPTH x 8 synchronous single-port RAM with one-cycle read latency, wrapped by the FSM.

Verification
REQ-033 Fetch: preload bytes 32=0x04 and 33=0x53, then pulse i_req with i_addr=16 -> i_ack 3 edges later with i_data=0x5304.
REQ-034 Read/write: write 0xAB to d_addr=0, then read d_addr=0 -> d_rdata=0xAB, d_err=0, each ack 2 edges after its request.
REQ-035 Collision: i_req and d_req high on the same edge -> d_ack first; the fetch then completes with i_ack 3 edges after returning to IDLE.
REQ-036 Protect: with SRAM_WPROT_EN defined, write 0xFF to d_addr=40 -> d_err=1 with d_ack and byte 40 unchanged; without it, byte 40 = 0xFF.
REQ-037 Reset: assert rst_n=0 during IF_HI -> no i_ack, state IDLE, outputs 0, array intact; a refetch returns the correct word.

Source files
------------

// File: rtl/sram_port_responder_pkg.sv
// Shared definitions for the fetch/data port FSM and the byte RAM core.
// Holds the state encoding, port address widths and the default protected-region base.
package sram_port_responder_pkg;

    localparam int IADDR_W = 8;
    localparam int DADDR_W = 9;
    localparam int DATA_W  = 8;
    localparam int unsigned PROT_BASE_DEF = 32;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        IF_LO = 3'd1,
        IF_HI = 3'd2,
        D_RD  = 3'd3,
        D_WR  = 3'd4,
        ACK   = 3'd5
    } state_t;

    function automatic logic addr_ok(input logic [DADDR_W-1:0] a, input int unsigned depth);
        return 32'(a) < depth;
    endfunction

endpackage

// File: rtl/sram_8bit_core.sv
// DEPTH x 8 single-port synchronous RAM; reads return data one cycle after en.
// No backpressure: every enabled cycle performs exactly one read or write.
module sram_8bit_core
    import sram_port_responder_pkg::*;
#(
    parameter int unsigned DEPTH = 512
) (
    input  logic               clk,
    input  logic               en,
    input  logic               we,
    input  logic [DADDR_W-1:0] addr,
    input  logic [DATA_W-1:0]  wdata,
    output logic [DATA_W-1:0]  rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                mem[addr] <= wdata;
            end else begin
                rdata <= mem[addr];
            end
        end
    end

endmodule

// File: rtl/sram_port_responder.sv
// Arbitrates an instruction-fetch port and a byte data port onto one byte RAM.
// Fetch acks 3 edges after acceptance, data 2; requests are held until ack. SRAM_WPROT_EN: write protect.
module sram_port_responder
    import sram_port_responder_pkg::*;
#(
    parameter int unsigned DEPTH     = 512,
    parameter int unsigned PROT_BASE = PROT_BASE_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               i_req,
    input  logic [IADDR_W-1:0] i_addr,
    output logic [15:0]        i_data,
    output logic               i_ack,
    input  logic               d_req,
    input  logic               d_we,
    input  logic [DADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0]  d_wdata,
    output logic [DATA_W-1:0]  d_rdata,
    output logic               d_ack,
    output logic               d_err
);

    state_t state, next;

    logic [IADDR_W-1:0] fa_q;
    logic [DADDR_W-1:0] da_q;
    logic [DATA_W-1:0]  dw_q;
    logic [DATA_W-1:0]  lo_q;

    logic               ram_en, ram_we;
    logic [DADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0]  ram_rdata;
    logic               wprot;

    logic [DADDR_W-1:0] lo_addr, hi_addr;
    assign lo_addr = {fa_q, 1'b0};
    assign hi_addr = {fa_q, 1'b1};

`ifdef SRAM_WPROT_EN
    assign wprot = 32'(da_q) >= PROT_BASE;
`else
    logic unused_prot;
    assign wprot       = 1'b0;
    assign unused_prot = ^PROT_BASE;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next;
        end
    end

    // The RAM read for the first byte is issued on the accepting edge so the
    // data is already on ram_rdata during the following state.
    always_comb begin
        next     = state;
        ram_en   = 1'b0;
        ram_we   = 1'b0;
        ram_addr = da_q;
        case (state)
            IDLE: begin
                if (d_req) begin
                    next     = d_we ? D_WR : D_RD;
                    ram_addr = d_addr;
                    ram_en   = !d_we && addr_ok(d_addr, DEPTH);
                end else if (i_req) begin
                    next     = IF_LO;
                    ram_addr = {i_addr, 1'b0};
                    ram_en   = addr_ok({i_addr, 1'b0}, DEPTH);
                end
            end
            IF_LO: begin
                next     = IF_HI;
                ram_addr = hi_addr;
                ram_en   = addr_ok(hi_addr, DEPTH);
            end
            IF_HI: next = ACK;
            D_RD:  next = ACK;
            D_WR: begin
                next     = ACK;
                ram_addr = da_q;
                // A reset landing on the write edge must leave the array untouched.
                ram_en   = rst_n && addr_ok(da_q, DEPTH) && !wprot;
                ram_we   = ram_en;
            end
            ACK:     next = IDLE;
            default: next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            i_ack   <= 1'b0;
            d_ack   <= 1'b0;
            d_err   <= 1'b0;
            i_data  <= '0;
            d_rdata <= '0;
            fa_q    <= '0;
            da_q    <= '0;
            dw_q    <= '0;
            lo_q    <= '0;
        end else begin
            i_ack <= 1'b0;
            d_ack <= 1'b0;
            d_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (d_req) begin
                        da_q <= d_addr;
                        dw_q <= d_wdata;
                    end else if (i_req) begin
                        fa_q <= i_addr;
                    end
                end
                IF_LO: lo_q <= addr_ok(lo_addr, DEPTH) ? ram_rdata : '0;
                IF_HI: begin
                    i_data <= {(addr_ok(hi_addr, DEPTH) ? ram_rdata : 8'h00), lo_q};
                    i_ack  <= 1'b1;
                end
                D_RD: begin
                    d_rdata <= addr_ok(da_q, DEPTH) ? ram_rdata : '0;
                    d_ack   <= 1'b1;
                end
                D_WR: begin
                    d_ack <= 1'b1;
                    d_err <= wprot;
                end
                default: ;
            endcase
        end
    end

    sram_8bit_core #(.DEPTH(DEPTH)) u_core (
        .clk   (clk),
        .en    (ram_en),
        .we    (ram_we),
        .addr  (ram_addr),
        .wdata (dw_q),
        .rdata (ram_rdata)
    );

endmodule

// File: tb/tb_sram_port_responder.sv
// Randomized scoreboard bench: driver pushes expected acks into queues, monitor pops on i_ack/d_ack.
module tb_sram_port_responder;
    import sram_port_responder_pkg::*;

    localparam int DEPTH = 512;
    localparam int PROT  = 32;
`ifdef SRAM_WPROT_EN
    localparam bit WPROT = 1'b1;
`else
    localparam bit WPROT = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        i_req = 1'b0;
    logic [7:0]  i_addr = '0;
    logic [15:0] i_data;
    logic        i_ack;
    logic        d_req = 1'b0;
    logic        d_we = 1'b0;
    logic [8:0]  d_addr = '0;
    logic [7:0]  d_wdata = '0;
    logic [7:0]  d_rdata;
    logic        d_ack;
    logic        d_err;

    sram_port_responder #(.DEPTH(DEPTH), .PROT_BASE(PROT)) dut (
        .clk(clk), .rst_n(rst_n),
        .i_req(i_req), .i_addr(i_addr), .i_data(i_data), .i_ack(i_ack),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_ack(d_ack), .d_err(d_err)
    );

    always #5 clk = ~clk;

    typedef struct { logic [15:0] data; bit chk; int edge_n; } iexp_t;
    typedef struct { logic [7:0] data; bit is_rd; bit chk; bit err; int edge_n; } dexp_t;

    iexp_t iq[$];
    dexp_t dq[$];

    logic [7:0] mem_m [DEPTH];
    bit         known [DEPTH];
    int cyc = 0;
    int free_edge = 0;
    int n_chk = 0;
    int n_fail = 0;
    logic [15:0] last_i = '0;
    bit          last_i_k = 1'b1;
    logic [7:0]  last_d = '0;
    bit          last_d_k = 1'b1;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic void mrd(input int a, output logic [7:0] v, output bit k);
        if (a >= DEPTH) begin
            v = 8'h00; k = 1'b1;
        end else begin
            v = mem_m[a]; k = known[a];
        end
    endfunction

    function automatic int accept_edge();
        return (cyc + 1 > free_edge) ? cyc + 1 : free_edge;
    endfunction

    task automatic exp_fetch(input logic [7:0] a, input int acc);
        iexp_t e;
        logic [7:0] lo, hi;
        bit klo, khi;
        mrd(2 * int'(a), lo, klo);
        mrd(2 * int'(a) + 1, hi, khi);
        e.data = {hi, lo};
        e.chk = klo && khi;
        e.edge_n = acc + 2;
        iq.push_back(e);
        free_edge = acc + 4;
    endtask

    task automatic exp_data(input bit we, input int a, input logic [7:0] wd, input int acc);
        dexp_t e;
        e.is_rd = !we;
        e.err = we && WPROT && (a >= PROT);
        e.edge_n = acc + 1;
        if (we) begin
            e.data = '0; e.chk = 1'b0;
            if (a < DEPTH && !e.err) begin
                mem_m[a] = wd; known[a] = 1'b1;
            end
        end else begin
            mrd(a, e.data, e.chk);
        end
        dq.push_back(e);
        free_edge = acc + 3;
    endtask

    task automatic do_fetch(input logic [7:0] a, output logic [15:0] got);
        bit done = 1'b0;
        exp_fetch(a, accept_edge());
        i_addr = a; i_req = 1'b1;
        for (int n = 0; n < 40 && !done; n++) begin
            tick();
            if (i_ack) done = 1'b1;
        end
        got = i_data;
        i_req = 1'b0;
        if (!done) check("fetch_timeout", 0, 1);
    endtask

    task automatic do_data(input bit we, input int a, input logic [7:0] wd, output logic [7:0] got);
        bit done = 1'b0;
        exp_data(we, a, wd, accept_edge());
        d_we = we; d_addr = 9'(a); d_wdata = wd; d_req = 1'b1;
        for (int n = 0; n < 40 && !done; n++) begin
            tick();
            if (d_ack) done = 1'b1;
        end
        got = d_rdata;
        d_req = 1'b0;
        if (!done) check("data_timeout", 0, 1);
    endtask

    task automatic do_collide(input logic [7:0] fa, input bit we, input int a, input logic [7:0] wd);
        bit di = 1'b0, ii = 1'b0;
        exp_data(we, a, wd, accept_edge());
        exp_fetch(fa, free_edge);
        i_addr = fa; d_we = we; d_addr = 9'(a); d_wdata = wd;
        i_req = 1'b1; d_req = 1'b1;
        for (int n = 0; n < 40 && !ii; n++) begin
            tick();
            if (d_ack) begin di = 1'b1; d_req = 1'b0; end
            if (i_ack) begin ii = 1'b1; i_req = 1'b0; end
        end
        i_req = 1'b0; d_req = 1'b0;
        if (!(di && ii)) check("collide_timeout", 0, 1);
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (i_ack) begin
                if (iq.size() == 0) check("i_ack_unexpected", 1, 0);
                else begin
                    iexp_t e;
                    e = iq.pop_front();
                    check("i_ack_latency", cyc, e.edge_n);
                    if (e.chk) check("i_data", 32'(i_data), 32'(e.data));
                    last_i = e.data; last_i_k = e.chk;
                end
            end else if (last_i_k) check("i_data_hold", 32'(i_data), 32'(last_i));
            if (d_ack) begin
                if (dq.size() == 0) check("d_ack_unexpected", 1, 0);
                else begin
                    dexp_t e;
                    e = dq.pop_front();
                    check("d_ack_latency", cyc, e.edge_n);
                    check("d_err", 32'(d_err), 32'(e.err));
                    if (e.is_rd) begin
                        if (e.chk) check("d_rdata", 32'(d_rdata), 32'(e.data));
                        last_d = e.data; last_d_k = e.chk;
                    end else if (last_d_k) check("d_rdata_hold_wr", 32'(d_rdata), 32'(last_d));
                end
            end else begin
                check("d_err_idle", 32'(d_err), 0);
                if (last_d_k) check("d_rdata_hold", 32'(d_rdata), 32'(last_d));
            end
        end
    end

    task automatic check_reset_outputs(input string tag);
        check({tag, "_i_ack"}, 32'(i_ack), 0);
        check({tag, "_d_ack"}, 32'(d_ack), 0);
        check({tag, "_d_err"}, 32'(d_err), 0);
        check({tag, "_i_data"}, 32'(i_data), 0);
        check({tag, "_d_rdata"}, 32'(d_rdata), 0);
        check({tag, "_state"}, 32'(dut.state), 32'(IDLE));
    endtask

    initial begin
        logic [15:0] gi;
        logic [7:0]  gd;
        int acc;

        for (int k = 0; k < DEPTH; k++) known[k] = 1'b0;

        repeat (3) tick();
        check_reset_outputs("por");
        last_i = '0; last_d = '0;
        rst_n = 1'b1;
        free_edge = cyc + 1;

        for (int a = 0; a < DEPTH; a++) do_data(1'b1, a, 8'($urandom), gd);

        do_data(1'b1, 32, 8'h04, gd);
        do_data(1'b1, 33, 8'h53, gd);
        do_fetch(8'd16, gi);
`ifndef SRAM_WPROT_EN
        check("fetch16_word", 32'(gi), 32'h5304);
`endif

        do_data(1'b1, 0, 8'hAB, gd);
        do_data(1'b0, 0, 8'h00, gd);
        check("rd0_data", 32'(gd), 32'hAB);

        do_collide(8'd16, 1'b0, 0, 8'h00);
        do_collide(8'd0, 1'b1, 1, 8'h5A);

        do_data(1'b1, 40, 8'hFF, gd);
        do_data(1'b0, 40, 8'h00, gd);
`ifndef SRAM_WPROT_EN
        check("byte40_written", 32'(gd), 32'hFF);
`endif

        do_data(1'b1, 510, 8'h3C, gd);
        do_data(1'b1, 511, 8'hC3, gd);
        do_fetch(8'd255, gi);

        acc = accept_edge();
        i_addr = 8'd16; i_req = 1'b1;
        while (cyc < acc + 1) tick();
        check("rst_in_if_hi", 32'(dut.state), 32'(IF_HI));
        rst_n = 1'b0;
        tick();
        i_req = 1'b0;
        check_reset_outputs("midrst");
        last_i = '0; last_i_k = 1'b1;
        last_d = '0; last_d_k = 1'b1;
        rst_n = 1'b1;
        free_edge = cyc + 1;
        do_fetch(8'd16, gi);
        do_data(1'b0, 1, 8'h00, gd);

        for (int t = 0; t < 400; t++) begin
            int kind;
            kind = int'($urandom_range(0, 3));
            repeat ($urandom_range(0, 2)) tick();
            case (kind)
                0: do_fetch(8'($urandom), gi);
                1: do_data(1'b0, int'($urandom_range(0, DEPTH - 1)), 8'h00, gd);
                2: do_data(1'b1, int'($urandom_range(0, DEPTH - 1)), 8'($urandom), gd);
                default: do_collide(8'($urandom), 1'($urandom),
                                    int'($urandom_range(0, DEPTH - 1)), 8'($urandom));
            endcase
        end

        repeat (6) tick();
        check("iq_drained", iq.size(), 0);
        check("dq_drained", dq.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish (cycle %0d)", cyc);
        $fatal(1);
    end

endmodule
